// File: rtl/regfile_pkg.sv
// Purpose: shared defaults and elaboration helpers for the parametrised register file.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NREGS  = 8;
    localparam int DEF_NREAD  = 2;
    localparam int DEF_ADDR_W = 4;

    // Ceiling log2, used only at elaboration to check NREGS against ADDR_W.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_param_onehot_dec.sv
// Purpose: select-to-one-hot decoder; all-zero when en is low or sel is out of range.
// Latency: purely combinational.
// Backpressure: none.
// Ports: sel (ADDR_W) and en in, onehot (NOUT) out.
module onehot_dec #(
    parameter int ADDR_W = 4,
    parameter int NOUT   = 8
) (
    input  logic [ADDR_W-1:0] sel,
    input  logic              en,
    output logic [NOUT-1:0]   onehot
);

    // Comparing against every legal index leaves sel >= NOUT with no match.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NOUT; i++) begin
            if (en && (sel == ADDR_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Purpose: register file, one write port, NREAD registered read ports, sticky out-of-range write flag.
// Latency: 1 edge for writes and reads; rdata and wr_err are registered (no input-to-output path).
// Backpressure: none; en and all selects are sampled every edge.
// Ports: clk, rst_n (sync, active-low), en/wsel/wdata write port, rsel/rdata packed read ports,
//        wr_err sticky error with err_clr.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREGS  = DEF_NREGS,
    parameter int NREAD  = DEF_NREAD,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [ADDR_W-1:0]       wsel,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [NREAD*ADDR_W-1:0] rsel,
    output logic [NREAD*WIDTH-1:0]  rdata,
    output logic                    wr_err,
    input  logic                    err_clr
);

    generate
        if (NREGS < 2 || clog2(NREGS) > ADDR_W) begin : g_bad_nregs
            $error("regfile_param: NREGS must be >= 2 and fit in ADDR_W select bits");
        end
        if (NREAD < 1) begin : g_bad_nread
            $error("regfile_param: NREAD must be at least 1");
        end
    endgenerate

    // One extra bit so NREGS == 2^ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W + 1)'(NREGS);

    logic [WIDTH-1:0]       regs [NREGS];
    logic [NREGS-1:0]       wr_onehot;
    logic                   wr_oob;
    logic [NREAD*WIDTH-1:0] rd_next;

    onehot_dec #(
        .ADDR_W (ADDR_W),
        .NOUT   (NREGS)
    ) u_wdec (
        .sel    (wsel),
        .en     (en),
        .onehot (wr_onehot)
    );

    assign wr_oob = en && ({1'b0, wsel} >= NREGS_W);

    // Read mux: scanning legal indices returns 0 for out-of-range selects.
    // With bypass, the decoder's enable bit doubles as the write/read match,
    // so out-of-range writes can never forward.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NREAD; i++) begin
            for (int j = 0; j < NREGS; j++) begin
                if (rsel[i*ADDR_W +: ADDR_W] == ADDR_W'(j)) begin
`ifdef REGFILE_BYPASS_EN
                    rd_next[i*WIDTH +: WIDTH] = wr_onehot[j] ? wdata : regs[j];
`else
                    rd_next[i*WIDTH +: WIDTH] = regs[j];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < NREGS; j++) begin
                regs[j] <= '0;
            end
            rdata  <= '0;
            wr_err <= 1'b0;
        end else begin
            for (int j = 0; j < NREGS; j++) begin
                if (wr_onehot[j]) begin
                    regs[j] <= wdata;
                end
            end
            rdata <= rd_next;
            // A new out-of-range write beats a clear in the same cycle.
            if (wr_oob) begin
                wr_err <= 1'b1;
            end else if (err_clr) begin
                wr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Purpose: self-checking bench for regfile_param against an array-based reference model.
// Latency: expects rdata/wr_err one edge after inputs are sampled.
// Backpressure: none; drives inputs every cycle.
module tb_regfile_param;

    localparam int W = 8;
    localparam int N = 8;
    localparam int R = 2;
    localparam int A = 4;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic           en      = 1'b0;
    logic           err_clr = 1'b0;
    logic [A-1:0]   wsel    = '0;
    logic [W-1:0]   wdata   = '0;
    logic [R*A-1:0] rsel    = '0;
    logic [R*W-1:0] rdata;
    logic           wr_err;

    int checks   = 0;
    int failures = 0;

    // Reference state: plain array of register contents plus expected outputs.
    logic [W-1:0] mem [N];
    logic [W-1:0] exp_rd [R];
    logic         exp_err;

    regfile_param #(
        .WIDTH  (W),
        .NREGS  (N),
        .NREAD  (R),
        .ADDR_W (A)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .wsel    (wsel),
        .wdata   (wdata),
        .rsel    (rsel),
        .rdata   (rdata),
        .wr_err  (wr_err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_rd(input int p0, input int p1);
        rsel[0*A +: A] = A'(p0);
        rsel[1*A +: A] = A'(p1);
    endtask

    // Predict the effect of the coming edge from the current inputs, then
    // advance one clock and compare every output against the prediction.
    task automatic tick();
        int s;
        int ws;
        ws = int'(wsel);
        if (!rst_n) begin
            for (int j = 0; j < N; j++) mem[j] = '0;
            for (int i = 0; i < R; i++) exp_rd[i] = '0;
            exp_err = 1'b0;
        end else begin
            for (int i = 0; i < R; i++) begin
                s = int'(rsel[i*A +: A]);
                exp_rd[i] = (s < N) ? mem[s] : '0;
`ifdef REGFILE_BYPASS_EN
                if (en && ws < N && ws == s) exp_rd[i] = wdata;
`endif
            end
            if (en && ws < N) mem[ws] = wdata;
            if (en && ws >= N) exp_err = 1'b1;
            else if (err_clr) exp_err = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < R; i++) begin
            check($sformatf("rdata%0d", i), 32'(rdata[i*W +: W]), 32'(exp_rd[i]));
        end
        check("wr_err", 32'(wr_err), 32'(exp_err));
    endtask

    task automatic read_all();
        en = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_rd(k, (k + 3) % N);
            tick();
        end
    endtask

    initial begin
        for (int j = 0; j < N; j++) mem[j] = '0;
        for (int i = 0; i < R; i++) exp_rd[i] = '0;
        exp_err = 1'b0;

        // Reset held for two edges while a write is presented.
        rst_n = 1'b0; en = 1'b1; wsel = 4'd3; wdata = 8'hFF;
        tick();
        tick();
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_wr_err", 32'(wr_err), 32'h0);
        rst_n = 1'b1;
        read_all();

        // Write every register, then read forward on port 0 and reversed on port 1.
        for (int k = 0; k < N; k++) begin
            en = 1'b1; wsel = A'(k); wdata = W'(8'h10 + k);
            tick();
        end
        en = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_rd(k, 7 - k);
            tick();
            check("rd_all_p0", 32'(rdata[7:0]), 32'(8'h10 + k));
            check("rd_all_p1", 32'(rdata[15:8]), 32'(8'h10 + 7 - k));
        end

        // Out-of-range write: flag sets, contents unchanged, clear works.
        en = 1'b1; wsel = 4'd9; wdata = 8'hAA;
        tick();
        check("oob_err_set", 32'(wr_err), 32'h1);
        en = 1'b0; set_rd(9, 0);
        tick();
        check("oob_read_zero", 32'(rdata[7:0]), 32'h0);
        read_all();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(wr_err), 32'h0);

        // Set and clear collide: set wins.
        en = 1'b1; wsel = 4'd12; err_clr = 1'b1;
        tick();
        check("err_collide", 32'(wr_err), 32'h1);
        en = 1'b0; err_clr = 1'b0;

        // Same-cycle write/read hazard on register 2.
        en = 1'b1; wsel = 4'd2; wdata = 8'h11;
        tick();
        wdata = 8'h22; set_rd(2, 2);
        tick();
`ifdef REGFILE_BYPASS_EN
        check("hazard_same", 32'(rdata[7:0]), 32'h22);
`else
        check("hazard_same", 32'(rdata[7:0]), 32'h11);
`endif
        en = 1'b0;
        tick();
        check("hazard_next", 32'(rdata[7:0]), 32'h22);

        // Reset pulse in the middle of back-to-back writes.
        for (int k = 0; k < 4; k++) begin
            en = 1'b1; wsel = A'(k + 4); wdata = W'(8'h30 + k);
            rst_n = (k != 2);
            tick();
        end
        rst_n = 1'b1;
        en = 1'b1; wsel = 4'd5; wdata = 8'h55;
        tick();
        read_all();
        set_rd(5, 6);
        tick();
        check("post_rst_write", 32'(rdata[7:0]), 32'h55);
        check("post_rst_lost", 32'(rdata[15:8]), 32'h0);

        // Randomised traffic with occasional resets and out-of-range selects.
        for (int n = 0; n < 400; n++) begin
            rst_n   = ($urandom_range(0, 49) != 0);
            en      = ($urandom_range(0, 2) != 0);
            wsel    = A'($urandom_range(0, 15));
            wdata   = W'($urandom);
            rsel    = R*A'($urandom);
            err_clr = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
